// File: rtl/register_file_if.sv
// register_file_if: write/read/clear request bundle and read/status response bundle for register_file
interface register_file_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2
);
    logic                  input_Write_Enable;
    logic [ADDR_WIDTH-1:0] input_Write_Register;
    logic [DATA_WIDTH-1:0] input_Write_Data;
    logic                  input_Read_Enable;
    logic [ADDR_WIDTH-1:0] input_Read_Register1;
    logic [ADDR_WIDTH-1:0] input_Read_Register2;
    logic                  input_Clear;
    logic [DATA_WIDTH-1:0] output_Read_Data1;
    logic [DATA_WIDTH-1:0] output_Read_Data2;
    logic                  output_Read_Valid;
    logic [DATA_WIDTH-1:0] output_Output;
    logic                  output_Busy;

    modport master (
        output input_Write_Enable, input_Write_Register, input_Write_Data,
        output input_Read_Enable, input_Read_Register1, input_Read_Register2,
        output input_Clear,
        input  output_Read_Data1, output_Read_Data2, output_Read_Valid,
        input  output_Output, output_Busy
    );

    modport slave (
        input  input_Write_Enable, input_Write_Register, input_Write_Data,
        input  input_Read_Enable, input_Read_Register1, input_Read_Register2,
        input  input_Clear,
        output output_Read_Data1, output_Read_Data2, output_Read_Valid,
        output output_Output, output_Busy
    );
endinterface

// File: rtl/register_file.sv
// register_file: dual-read single-write register file with registered reads and a one-register-per-cycle clear sweep.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to a read port addressing the written register.
module register_file #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2
) (
    input logic           input_Clock,
    input logic           input_Reset,
    register_file_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];
    logic [DATA_WIDTH-1:0] rd1_q, rd1_d, rd2_q, rd2_d, out_q, out_d;
    logic                  valid_q, valid_d;
    logic                  idle, wr_ok;
    logic [DATA_WIDTH-1:0] rdata1, rdata2;

    assign idle  = state_q == IDLE;
    // Clear wins over a simultaneous write, so a dropped write must not be forwarded either.
    assign wr_ok = idle && bus.input_Write_Enable && !bus.input_Clear;

`ifdef REGFILE_BYPASS_EN
    assign rdata1 = (wr_ok && bus.input_Write_Register == bus.input_Read_Register1) ? bus.input_Write_Data : regs_q[bus.input_Read_Register1];
    assign rdata2 = (wr_ok && bus.input_Write_Register == bus.input_Read_Register2) ? bus.input_Write_Data : regs_q[bus.input_Read_Register2];
`else
    assign rdata1 = regs_q[bus.input_Read_Register1];
    assign rdata2 = regs_q[bus.input_Read_Register2];
`endif

    // Next-state: IDLE serves reads, writes and clear requests; CLEAR zeroes one register per cycle and ignores requests.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        regs_d  = regs_q;
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        out_d   = out_q;
        valid_d = 1'b0;
        if (idle) begin
            if (bus.input_Clear) begin
                state_d = CLEAR;
                cnt_d   = '0;
                out_d   = '0;
            end else if (bus.input_Write_Enable) begin
                regs_d[bus.input_Write_Register] = bus.input_Write_Data;
                out_d = bus.input_Write_Data;
            end
            if (bus.input_Read_Enable) begin
                rd1_d   = rdata1;
                rd2_d   = rdata2;
                valid_d = 1'b1;
            end
        end else begin
            regs_d[cnt_q] = '0;
            state_d = (cnt_q == LAST) ? IDLE : CLEAR;
            cnt_d   = (cnt_q == LAST) ? cnt_q : cnt_q + 1'b1;
        end
    end

    // State registers with asynchronous reset that also aborts any sweep in progress.
    always_ff @(posedge input_Clock or posedge input_Reset) begin
        if (input_Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            regs_q  <= regs_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign bus.output_Read_Data1 = rd1_q;
    assign bus.output_Read_Data2 = rd2_q;
    assign bus.output_Read_Valid = valid_q;
    assign bus.output_Output     = out_q;
    assign bus.output_Busy       = state_q == CLEAR;
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: randomized and directed checks of register_file against an array-based reference model
module tb_register_file;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    register_file_if b8 ();
    register_file_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) b16 ();

    register_file dut8 (.input_Clock(clk), .input_Reset(rst), .bus(b8));
    register_file #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dut16 (.input_Clock(clk), .input_Reset(rst), .bus(b16));

    logic [7:0] mem [4];
    logic [7:0] m_rd1, m_rd2, m_out;
    logic       m_valid;
    int         busy_left;
    int         total = 0;
    int         bad = 0;
    int         n;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mem[i] = 8'h00;
        m_rd1 = 8'h00; m_rd2 = 8'h00; m_out = 8'h00; m_valid = 1'b0; busy_left = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_rd1"}, b8.output_Read_Data1, m_rd1);
        chk({tag, "_rd2"}, b8.output_Read_Data2, m_rd2);
        chk({tag, "_valid"}, b8.output_Read_Valid, m_valid);
        chk({tag, "_out"}, b8.output_Output, m_out);
        chk({tag, "_busy"}, b8.output_Busy, busy_left > 0);
    endtask

    task automatic idle8();
        b8.input_Write_Enable = 1'b0; b8.input_Read_Enable = 1'b0; b8.input_Clear = 1'b0;
    endtask

    // One clock of the 8-bit DUT; the model applies the block's rules to the pre-edge state.
    task automatic step(input logic we, input logic [1:0] wa, input logic [7:0] wd,
                        input logic re, input logic [1:0] r1, input logic [1:0] r2,
                        input logic clr, input string tag);
        b8.input_Write_Enable = we; b8.input_Write_Register = wa; b8.input_Write_Data = wd;
        b8.input_Read_Enable = re; b8.input_Read_Register1 = r1; b8.input_Read_Register2 = r2;
        b8.input_Clear = clr;
        @(posedge clk);
        if (busy_left > 0) begin
            busy_left--;
            m_valid = 1'b0;
        end else begin
            m_valid = re;
            if (re) begin
                m_rd1 = (BYP && we && !clr && wa == r1) ? wd : mem[r1];
                m_rd2 = (BYP && we && !clr && wa == r2) ? wd : mem[r2];
            end
            if (clr) begin
                for (int i = 0; i < 4; i++) mem[i] = 8'h00;
                m_out = 8'h00;
                busy_left = 4;
            end else if (we) begin
                mem[wa] = wd;
                m_out = wd;
            end
        end
        #1;
        check_all(tag);
        idle8();
    endtask

    initial begin
        rst = 1'b1;
        idle8();
        b8.input_Write_Register = '0; b8.input_Write_Data = '0;
        b8.input_Read_Register1 = '0; b8.input_Read_Register2 = '0;
        b16.input_Write_Enable = 1'b0; b16.input_Read_Enable = 1'b0; b16.input_Clear = 1'b0;
        b16.input_Write_Register = '0; b16.input_Write_Data = '0;
        b16.input_Read_Register1 = '0; b16.input_Read_Register2 = '0;
        model_reset();
        #12;
        check_all("reset");
        chk("reset16_out", b16.output_Output, 32'h0);
        chk("reset16_busy", b16.output_Busy, 32'h0);
        rst = 1'b0;

        step(1'b1, 2'd2, 8'hA5, 1'b0, 2'd0, 2'd0, 1'b0, "w_a5");
        step(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 2'd2, 1'b0, "r_a5");
        chk("a5_rd1", b8.output_Read_Data1, 32'hA5);
        chk("a5_rd2", b8.output_Read_Data2, 32'hA5);
        chk("a5_valid", b8.output_Read_Valid, 32'h1);
        step(1'b0, 2'd0, 8'h00, 1'b0, 2'd1, 2'd1, 1'b0, "hold");
        chk("a5_valid_drop", b8.output_Read_Valid, 32'h0);
        chk("a5_hold", b8.output_Read_Data1, 32'hA5);

        step(1'b1, 2'd1, 8'h11, 1'b0, 2'd0, 2'd0, 1'b0, "w_11");
        step(1'b1, 2'd1, 8'h3C, 1'b1, 2'd1, 2'd2, 1'b0, "fwd");
        chk("fwd_rd1", b8.output_Read_Data1, BYP ? 32'h3C : 32'h11);
        chk("fwd_rd2", b8.output_Read_Data2, 32'hA5);

        for (int i = 0; i < 4; i++) step(1'b1, 2'(i), 8'(i + 1), 1'b0, 2'd0, 2'd0, 1'b0, "fill");
        step(1'b1, 2'd3, 8'hFF, 1'b0, 2'd0, 2'd0, 1'b1, "clr_start");
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (!b8.output_Busy) break;
            n++;
            step(1'b1, 2'(i), 8'h77, 1'b1, 2'd0, 2'd1, 1'b1, "sweep");
        end
        chk("busy_len", n, 32'd4);
        chk("clr_out", b8.output_Output, 32'h0);
        step(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 2'd1, 1'b0, "clr_rd01");
        step(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 2'd3, 1'b0, "clr_rd23");
        chk("clr_rd3", b8.output_Read_Data2, 32'h0);

        step(1'b1, 2'd0, 8'h5E, 1'b0, 2'd0, 2'd0, 1'b0, "pre_abort");
        step(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0, 1'b1, "abort_clr");
        step(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0, 1'b0, "abort_sw1");
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        #10 rst = 1'b0;
        step(1'b1, 2'd3, 8'h5A, 1'b0, 2'd0, 2'd0, 1'b0, "post_rst_w");
        step(1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 2'd0, 1'b0, "post_rst_r");
        chk("post_rst_rd1", b8.output_Read_Data1, 32'h5A);

        for (int i = 0; i < 300; i++)
            step(1'($urandom), 2'($urandom), 8'($urandom), 1'($urandom), 2'($urandom), 2'($urandom),
                 ($urandom % 20) == 0, "rand");
        for (int i = 0; i < 10 && busy_left > 0; i++)
            step(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0, 1'b0, "drain");

        b16.input_Write_Enable = 1'b1; b16.input_Write_Register = 3'd7; b16.input_Write_Data = 16'hBEEF;
        @(posedge clk); #1;
        b16.input_Write_Enable = 1'b0;
        chk("w16_out", b16.output_Output, 32'hBEEF);
        b16.input_Read_Enable = 1'b1; b16.input_Read_Register1 = 3'd0; b16.input_Read_Register2 = 3'd7;
        @(posedge clk); #1;
        b16.input_Read_Enable = 1'b0;
        chk("r16_rd2", b16.output_Read_Data2, 32'hBEEF);
        chk("r16_valid", b16.output_Read_Valid, 32'h1);
        b16.input_Clear = 1'b1;
        @(posedge clk); #1;
        b16.input_Clear = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (!b16.output_Busy) break;
            n++;
            @(posedge clk); #1;
        end
        chk("busy16_len", n, 32'd8);
        b16.input_Read_Enable = 1'b1;
        @(posedge clk); #1;
        b16.input_Read_Enable = 1'b0;
        chk("clr16_rd2", b16.output_Read_Data2, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
